// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial subtractor.
// The master drives operands and start; the slave (the subtractor) returns status and results.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one full-subtractor step per clock, LSB first.
// Published results (diff/bout/ovf) only change on the cycle an operation completes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] aShift_q, aShift_d;
    logic [WIDTH-1:0] bShift_q, bShift_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    count_q, count_d;
    logic             borrow_q, borrow_d;
    logic             aMsb_q, aMsb_d;
    logic             bMsb_q, bMsb_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic             diffBit;
    logic             borrowNext;
    logic [WIDTH-1:0] resultShifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            aShift_q <= '0;
            bShift_q <= '0;
            result_q <= '0;
            diff_q   <= '0;
            count_q  <= '0;
            borrow_q <= 1'b0;
            aMsb_q   <= 1'b0;
            bMsb_q   <= 1'b0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            aShift_q <= aShift_d;
            bShift_q <= bShift_d;
            result_q <= result_d;
            diff_q   <= diff_d;
            count_q  <= count_d;
            borrow_q <= borrow_d;
            aMsb_q   <= aMsb_d;
            bMsb_q   <= bMsb_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        aShift_d      = aShift_q;
        bShift_d      = bShift_q;
        result_d      = result_q;
        diff_d        = diff_q;
        count_d       = count_q;
        borrow_d      = borrow_q;
        aMsb_d        = aMsb_q;
        bMsb_d        = bMsb_q;
        bout_d        = bout_q;
        ovf_d         = ovf_q;

        diffBit       = aShift_q[0] ^ bShift_q[0] ^ borrow_q;
        borrowNext    = (~aShift_q[0] & bShift_q[0]) |
                        (~(aShift_q[0] ^ bShift_q[0]) & borrow_q);
        resultShifted = result_q >> 1;
        resultShifted[WIDTH-1] = diffBit;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    aShift_d = bus.a;
                    bShift_d = bus.b;
                    borrow_d = bus.bin;
                    aMsb_d   = bus.a[WIDTH-1];
                    bMsb_d   = bus.b[WIDTH-1];
                    count_d  = '0;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                aShift_d = aShift_q >> 1;
                bShift_d = bShift_q >> 1;
                borrow_d = borrowNext;
                result_d = resultShifted;
                count_d  = count_q + CW'(1);
                // The last bit's diff is also the result MSB, so overflow is decided here.
                if (count_q == LAST_BIT) begin
                    state_d = DONE;
                    diff_d  = resultShifted;
                    bout_d  = borrowNext;
                    ovf_d   = (aMsb_q ^ bMsb_q) & (diffBit ^ aMsb_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH 8, 3 and 1.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(3)) if3 ();
    serial_subtractor_if #(.WIDTH(1)) if1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_subtractor #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    int errors = 0;
    int checks = 0;
    int lat;
    int busyCnt, doneCnt, doneAt, idleGap, idx;
    logic [7:0] opA [3];
    logic [7:0] opB [3];
    logic       opBin [3];
    logic [7:0] expDiff [3];
    logic       expBout [3];
    logic       expOvf [3];
    int         full;
    logic [2:0] m3, av, bv;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic getDone(input int w);
        case (w)
            8: return if8.done;
            3: return if3.done;
            default: return if1.done;
        endcase
    endfunction

    function automatic logic [7:0] getDiff(input int w);
        case (w)
            8: return if8.diff;
            3: return {5'b0, if3.diff};
            default: return {7'b0, if1.diff};
        endcase
    endfunction

    function automatic logic getBout(input int w);
        case (w)
            8: return if8.bout;
            3: return if3.bout;
            default: return if1.bout;
        endcase
    endfunction

    function automatic logic getOvf(input int w);
        case (w)
            8: return if8.ovf;
            3: return if3.ovf;
            default: return if1.ovf;
        endcase
    endfunction

    // Present one operation, scramble the operands after the accept edge, and wait
    // (bounded) for done; lat counts falling edges from just after the accept edge.
    task automatic applyStimulus(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic bin, output int latency);
        @(negedge clk);
        case (w)
            8: begin if8.a = a; if8.b = b; if8.bin = bin; if8.start = 1'b1; end
            3: begin if3.a = a[2:0]; if3.b = b[2:0]; if3.bin = bin; if3.start = 1'b1; end
            default: begin if1.a = a[0]; if1.b = b[0]; if1.bin = bin; if1.start = 1'b1; end
        endcase
        @(negedge clk);
        case (w)
            8: begin if8.a = ~a; if8.b = ~b; if8.bin = ~bin; if8.start = 1'b0; end
            3: begin if3.a = ~a[2:0]; if3.b = ~b[2:0]; if3.bin = ~bin; if3.start = 1'b0; end
            default: begin if1.a = ~a[0]; if1.b = ~b[0]; if1.bin = ~bin; if1.start = 1'b0; end
        endcase
        latency = 0;
        while (!getDone(w) && latency < 100) begin
            @(negedge clk);
            latency++;
        end
    endtask

    task automatic runAndCheck8(input string tag, input logic [7:0] a, input logic [7:0] b,
                                input logic bin, input logic [7:0] eDiff, input logic eBout,
                                input logic eOvf);
        int l;
        applyStimulus(8, a, b, bin, l);
        checkOutput({tag, ".latency"}, 64'(l), 64'(8));
        checkOutput({tag, ".diff"}, 64'(if8.diff), 64'(eDiff));
        checkOutput({tag, ".bout"}, 64'(if8.bout), 64'(eBout));
        checkOutput({tag, ".ovf"}, 64'(if8.ovf), 64'(eOvf));
    endtask

    initial begin
        if8.start = 0; if8.a = '0; if8.b = '0; if8.bin = 0;
        if3.start = 0; if3.a = '0; if3.b = '0; if3.bin = 0;
        if1.start = 0; if1.a = '0; if1.b = '0; if1.bin = 0;

        // Reset values on every instance.
        #12;
        checkOutput("rst.busy8", 64'(if8.busy), 64'(0));
        checkOutput("rst.done8", 64'(if8.done), 64'(0));
        checkOutput("rst.diff8", 64'(if8.diff), 64'(0));
        checkOutput("rst.bout8", 64'(if8.bout), 64'(0));
        checkOutput("rst.ovf8", 64'(if8.ovf), 64'(0));
        checkOutput("rst.diff3", 64'(if3.diff), 64'(0));
        checkOutput("rst.busy1", 64'(if1.busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic subtraction, then one-cycle done pulse with results held.
        runAndCheck8("t05m03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t05m03.donePulse", 64'(if8.done), 64'(0));
        checkOutput("t05m03.hold", 64'(if8.diff), 64'(8'h02));

        runAndCheck8("t03m05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        runAndCheck8("t80m01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        runAndCheck8("t7Fm FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

        // start pulses during RUN are ignored; outputs hold the previous result meanwhile.
        @(negedge clk);
        if8.a = 8'h5A; if8.b = 8'h21; if8.bin = 1'b0; if8.start = 1'b1;
        @(negedge clk);
        if8.a = 8'hFF; if8.b = 8'h00; if8.start = 1'b0;
        busyCnt = 0; doneCnt = 0; doneAt = -1;
        for (int j = 0; j < 12; j++) begin
            if (if8.busy) busyCnt++;
            if (if8.done) begin doneCnt++; doneAt = j; end
            if (j == 3) begin
                checkOutput("ign.holdDiff", 64'(if8.diff), 64'(8'h80));
                checkOutput("ign.holdBout", 64'(if8.bout), 64'(1));
                checkOutput("ign.holdOvf", 64'(if8.ovf), 64'(1));
            end
            if8.start = (j == 2 || j == 4 || j == 6);
            @(negedge clk);
        end
        if8.start = 1'b0;
        checkOutput("ign.busyCycles", 64'(busyCnt), 64'(8));
        checkOutput("ign.doneCount", 64'(doneCnt), 64'(1));
        checkOutput("ign.doneAt", 64'(doneAt), 64'(8));
        checkOutput("ign.diff", 64'(if8.diff), 64'(8'h39));

        // Borrow-in, and a 16-bit 0x0100 - 0x0001 built from two chained bytes.
        runAndCheck8("t00m00b1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        runAndCheck8("chainLo", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        runAndCheck8("chainHi", 8'h01, 8'h00, if8.bout, 8'h00, 1'b0, 1'b0);

        // start held high: back-to-back operations, busy only drops for the DONE cycle.
        opA = '{8'h10, 8'h80, 8'h00}; opB = '{8'h01, 8'h01, 8'h00}; opBin = '{1'b0, 1'b0, 1'b1};
        expDiff = '{8'h0F, 8'h7F, 8'hFF}; expBout = '{1'b0, 1'b0, 1'b1}; expOvf = '{1'b0, 1'b1, 1'b0};
        @(negedge clk);
        idx = 0; idleGap = 0;
        if8.a = opA[0]; if8.b = opB[0]; if8.bin = opBin[0]; if8.start = 1'b1;
        for (int j = 0; j < 60 && idx < 3; j++) begin
            @(negedge clk);
            if (!if8.busy && !if8.done) idleGap++;
            if (if8.done) begin
                checkOutput($sformatf("b2b%0d.diff", idx), 64'(if8.diff), 64'(expDiff[idx]));
                checkOutput($sformatf("b2b%0d.bout", idx), 64'(if8.bout), 64'(expBout[idx]));
                checkOutput($sformatf("b2b%0d.ovf", idx), 64'(if8.ovf), 64'(expOvf[idx]));
                idx++;
                if (idx < 3) begin
                    if8.a = opA[idx]; if8.b = opB[idx]; if8.bin = opBin[idx];
                end else begin
                    if8.start = 1'b0;
                end
            end
        end
        if8.start = 1'b0;
        checkOutput("b2b.completed", 64'(idx), 64'(3));
        checkOutput("b2b.idleGap", 64'(idleGap), 64'(0));

        // Reset in the middle of a run aborts it and clears the published result.
        runAndCheck8("preRst", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        if8.a = 8'h33; if8.b = 8'h11; if8.bin = 1'b0; if8.start = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midRst.busy", 64'(if8.busy), 64'(0));
        checkOutput("midRst.done", 64'(if8.done), 64'(0));
        checkOutput("midRst.diff", 64'(if8.diff), 64'(0));
        checkOutput("midRst.bout", 64'(if8.bout), 64'(0));
        checkOutput("midRst.ovf", 64'(if8.ovf), 64'(0));
        #3;
        rst_n = 1'b1;
        doneCnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done || if8.busy) doneCnt++;
        end
        checkOutput("midRst.noActivity", 64'(doneCnt), 64'(0));
        runAndCheck8("postRst", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

        // WIDTH=3 exhaustive against an arithmetic model.
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                for (int c = 0; c < 2; c++) begin
                    applyStimulus(3, 8'(a), 8'(b), c[0], lat);
                    full = a - b - c;
                    m3 = full[2:0];
                    av = 3'(a);
                    bv = 3'(b);
                    checkOutput($sformatf("w3.lat a%0d b%0d c%0d", a, b, c), 64'(lat), 64'(3));
                    checkOutput($sformatf("w3.diff a%0d b%0d c%0d", a, b, c), 64'(getDiff(3)), 64'(m3));
                    checkOutput($sformatf("w3.bout a%0d b%0d c%0d", a, b, c), 64'(getBout(3)), 64'(full < 0));
                    checkOutput($sformatf("w3.ovf a%0d b%0d c%0d", a, b, c), 64'(getOvf(3)),
                                64'((av[2] != bv[2]) && (m3[2] != av[2])));
                end
            end
        end

        // WIDTH=1 full-subtractor truth table; the operand MSB is the operand itself.
        for (int r = 0; r < 8; r++) begin
            applyStimulus(1, 8'(r[2]), 8'(r[1]), r[0], lat);
            full = int'(r[2]) - int'(r[1]) - int'(r[0]);
            checkOutput($sformatf("w1.lat row%0d", r), 64'(lat), 64'(1));
            checkOutput($sformatf("w1.diff row%0d", r), 64'(getDiff(1)), 64'(full[0]));
            checkOutput($sformatf("w1.bout row%0d", r), 64'(getBout(1)), 64'(full < 0));
            checkOutput($sformatf("w1.ovf row%0d", r), 64'(getOvf(1)),
                        64'((r[2] != r[1]) && (full[0] != r[2])));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
